// File: rtl/c1541_head_seek.sv
// C1541 head positioner: steps the half-track stepper toward a requested track,
// handling motor spin-up, inter-step delay, head settle and motor run-on.
module c1541_head_seek #(
  parameter int unsigned STEP_CYCLES   = 96000,
  parameter int unsigned SPINUP_CYCLES = 3200000,
  parameter int unsigned SETTLE_CYCLES = 480000,
  parameter int unsigned HOLD_CYCLES   = 32000000
) (
  input  logic       clk32,
  input  logic       reset,
  input  logic       seek_req,
  input  logic [6:0] target_ht,
  input  logic       motor_on,
  output logic [1:0] stp,
  output logic       mtr,
  output logic [6:0] cur_ht,
  output logic       busy,
  output logic       done
);

  localparam int unsigned MAX_A    = (STEP_CYCLES > SPINUP_CYCLES) ? STEP_CYCLES : SPINUP_CYCLES;
  localparam int unsigned MAX_WAIT = (MAX_A > SETTLE_CYCLES) ? MAX_A : SETTLE_CYCLES;
  localparam int unsigned CW       = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  localparam int unsigned HOLD_EFF = (HOLD_CYCLES == 0) ? 1 : HOLD_CYCLES;
  localparam int unsigned HW       = (HOLD_EFF < 2) ? 1 : $clog2(HOLD_EFF + 1);

  // A state lasting N cycles is loaded with N-1 and left when the counter hits 0,
  // so a zero-cycle parameter still yields exactly one cycle in that state.
  localparam logic [CW-1:0] STEP_LD   = CW'((STEP_CYCLES   == 0) ? 0 : STEP_CYCLES - 1);
  localparam logic [CW-1:0] SPINUP_LD = CW'((SPINUP_CYCLES == 0) ? 0 : SPINUP_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LD = CW'((SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LD   = HW'(HOLD_EFF);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SPINUP,
    S_STEP,
    S_WAIT,
    S_SETTLE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [6:0]    cur_q, cur_d;
  logic [6:0]    tgt_q, tgt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [6:0]    tgt_clamped;
  logic          motor_running;

  always_comb begin
    tgt_clamped   = (target_ht == 7'd0) ? 7'd1 : ((target_ht > 7'd80) ? 7'd80 : target_ht);
    motor_running = motor_on || (hold_q != '0);

    state_d = state_q;
    cnt_d   = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
    cur_d   = cur_q;
    tgt_d   = tgt_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (seek_req) begin
          tgt_d = tgt_clamped;
          if (!motor_running) begin
            state_d = S_SPINUP;
            cnt_d   = SPINUP_LD;
          end else if (tgt_clamped == cur_q) begin
            state_d = S_SETTLE;
            cnt_d   = SETTLE_LD;
          end else begin
            state_d = S_STEP;
          end
        end
      end
      S_SPINUP: begin
        if (cnt_q == '0) begin
          if (tgt_q == cur_q) begin
            state_d = S_SETTLE;
            cnt_d   = SETTLE_LD;
          end else begin
            state_d = S_STEP;
          end
        end
      end
      S_STEP: begin
        if (tgt_q > cur_q) begin
          cur_d = cur_q + 7'd1;
        end else if (tgt_q < cur_q) begin
          cur_d = cur_q - 7'd1;
        end
        state_d = S_WAIT;
        cnt_d   = STEP_LD;
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          if (tgt_q != cur_q) begin
            state_d = S_STEP;
          end else begin
            state_d = S_SETTLE;
            cnt_d   = SETTLE_LD;
          end
        end
      end
      S_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // busy is registered so it still covers the done cycle, which is already IDLE
    busy_d = (state_d != S_IDLE) || done_d;

    if (done_d || motor_on) begin
      hold_d = HOLD_LD;
    end else if (hold_q != '0) begin
      hold_d = hold_q - 1'b1;
    end else begin
      hold_d = hold_q;
    end
  end

  always_ff @(posedge clk32) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
      cur_q   <= 7'd36;
      tgt_q   <= 7'd36;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      cur_q   <= cur_d;
      tgt_q   <= tgt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign cur_ht = cur_q;
  assign stp    = {cur_q[0], cur_q[1]};
  assign mtr    = (state_q != S_IDLE) || motor_on || (hold_q != '0);
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_c1541_head_seek.sv
// Bench for c1541_head_seek: per-scenario tasks plus a per-cycle timeline scoreboard.
module tb_c1541_head_seek;

  localparam int SP = 8;
  localparam int ST = 4;
  localparam int SE = 6;
  localparam int HO = 10;

  logic       clk32 = 1'b0;
  logic       reset = 1'b1;
  logic       seek_req = 1'b0;
  logic [6:0] target_ht = 7'd0;
  logic       motor_on = 1'b0;
  logic [1:0] stp;
  logic       mtr;
  logic [6:0] cur_ht;
  logic       busy;
  logic       done;

  int n_cmp = 0;
  int n_bad = 0;

  c1541_head_seek #(
    .STEP_CYCLES  (ST),
    .SPINUP_CYCLES(SP),
    .SETTLE_CYCLES(SE),
    .HOLD_CYCLES  (HO)
  ) dut (
    .clk32    (clk32),
    .reset    (reset),
    .seek_req (seek_req),
    .target_ht(target_ht),
    .motor_on (motor_on),
    .stp      (stp),
    .mtr      (mtr),
    .cur_ht   (cur_ht),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk32 = ~clk32;

  // ---------------- reference timeline model ----------------
  typedef struct packed {
    logic [6:0] cur;
    logic       dn;
  } ent_t;

  ent_t       sb_q[$];
  logic [6:0] m_cur = 7'd36;
  int         hold_left = 0;
  bit         sb_en = 1'b0;
  logic [6:0] e_cur;
  logic [1:0] e_stp;
  logic       e_busy, e_done, e_mtr, idle_now, was_done;

  function automatic logic [6:0] clamp_ht(input logic [6:0] t);
    if (t == 0) return 7'd1;
    if (t > 80) return 7'd80;
    return t;
  endfunction

  // Expected per-cycle head position from the cycle after acceptance to the done cycle.
  function automatic void build_timeline(input logic [6:0] t_raw, input logic running);
    int c, t;
    c = m_cur;
    t = clamp_ht(t_raw);
    if (!running) repeat (SP) sb_q.push_back('{cur: 7'(c), dn: 1'b0});
    while (c != t) begin
      sb_q.push_back('{cur: 7'(c), dn: 1'b0});
      c = (c < t) ? c + 1 : c - 1;
      repeat (ST) sb_q.push_back('{cur: 7'(c), dn: 1'b0});
    end
    repeat (SE) sb_q.push_back('{cur: 7'(c), dn: 1'b0});
    sb_q.push_back('{cur: 7'(c), dn: 1'b1});
    m_cur = 7'(c);
  endfunction

  always @(negedge clk32) begin
    if (sb_en) begin
      if (sb_q.size() > 0) begin
        e_cur = sb_q[0].cur; e_busy = 1'b1; e_done = sb_q[0].dn; e_mtr = 1'b1;
      end else begin
        e_cur = m_cur; e_busy = 1'b0; e_done = 1'b0; e_mtr = motor_on || (hold_left > 0);
      end
      e_stp = {e_cur[0], e_cur[1]};
      n_cmp++;
      if ({cur_ht, stp, busy, done, mtr} !== {e_cur, e_stp, e_busy, e_done, e_mtr}) begin
        n_bad++;
        $display("FAIL scoreboard t=%0t: cur_ht=%0d stp=%0d busy=%b done=%b mtr=%b, expected cur_ht=%0d stp=%0d busy=%b done=%b mtr=%b",
                 $time, cur_ht, stp, busy, done, mtr, e_cur, e_stp, e_busy, e_done, e_mtr);
      end
    end
    if (reset) begin
      sb_q.delete();
      m_cur = 7'd36;
      hold_left = 0;
      sb_en = 1'b1;
    end else if (sb_en) begin
      was_done = (sb_q.size() > 0) && sb_q[0].dn;
      idle_now = (sb_q.size() == 0) || was_done;
      if (sb_q.size() > 0) void'(sb_q.pop_front());
      if (motor_on) hold_left = HO;
      else if (was_done) hold_left = HO - 1;
      else if (hold_left > 0) hold_left--;
      if (idle_now && seek_req) build_timeline(target_ht, e_mtr);
    end
  end

  // ---------------- stimulus helpers (observation only) ----------------
  logic [1:0] obs_v[$];
  int         obs_at[$];
  int         done_at, done_cnt, fall_at, min_cur, max_cur;
  logic       mtr1;

  task automatic tick();
    @(posedge clk32);
    #1;
  endtask

  task automatic do_reset();
    motor_on = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic do_seek(input logic [6:0] tgt, input int second_at, input logic [6:0] tgt2, input int extra);
    logic [1:0] prev;
    int off;
    obs_v.delete(); obs_at.delete();
    done_at = -1; done_cnt = 0; fall_at = -1; min_cur = 127; max_cur = 0; mtr1 = 1'b0;
    prev = stp;
    target_ht = tgt; seek_req = 1'b1;
    tick();
    seek_req = 1'b0;
    off = 1;
    while (off < 2000 && (done_at < 0 || off <= done_at + extra)) begin
      if (off == 1) mtr1 = mtr;
      if (off == second_at) begin target_ht = tgt2; seek_req = 1'b1; end
      else seek_req = 1'b0;
      if (stp !== prev) begin obs_v.push_back(stp); obs_at.push_back(off); prev = stp; end
      if (done === 1'b1) begin done_cnt++; if (done_at < 0) done_at = off; end
      if (mtr === 1'b0 && fall_at < 0) fall_at = off;
      if (int'(cur_ht) < min_cur) min_cur = int'(cur_ht);
      if (int'(cur_ht) > max_cur) max_cur = int'(cur_ht);
      tick();
      off++;
    end
    seek_req = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({cur_ht, stp, mtr, busy, done} !== {7'd36, 2'd0, 1'b0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_state: got cur_ht=%0d stp=%0d mtr=%b busy=%b done=%b, expected 36/0/0/0/0",
               cur_ht, stp, mtr, busy, done);
    end
  endtask

  task automatic test_seek_up_spinup();
    logic [1:0] ev[2];
    int ea[2];
    ev = '{2'd2, 2'd1};
    ea = '{SP + 2, SP + ST + 3};
    do_reset();
    do_seek(7'd38, 0, 7'd0, HO + 2);
    n_cmp++;
    if (mtr1 !== 1'b1) begin n_bad++; $display("FAIL up_mtr_immediate: got %b expected 1", mtr1); end
    n_cmp++;
    if (obs_v.size() != 2) begin n_bad++; $display("FAIL up_step_count: got %0d expected 2", obs_v.size()); end
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (i >= obs_v.size()) begin
        n_bad++; $display("FAIL up_step%0d: missing, expected stp=%0d at %0d", i, ev[i], ea[i]);
      end else if (obs_v[i] !== ev[i] || obs_at[i] != ea[i]) begin
        n_bad++;
        $display("FAIL up_step%0d: got stp=%0d at %0d, expected stp=%0d at %0d", i, obs_v[i], obs_at[i], ev[i], ea[i]);
      end
    end
    n_cmp++;
    if (cur_ht !== 7'd38) begin n_bad++; $display("FAIL up_cur_ht: got %0d expected 38", cur_ht); end
    n_cmp++;
    if (done_at != SP + 2 * (ST + 1) + SE + 1 || done_cnt != 1) begin
      n_bad++;
      $display("FAIL up_done: got at %0d count %0d, expected at %0d count 1", done_at, done_cnt, SP + 2 * (ST + 1) + SE + 1);
    end
    n_cmp++;
    if (fall_at != done_at + HO) begin
      n_bad++; $display("FAIL up_mtr_fall: got %0d expected %0d", fall_at, done_at + HO);
    end
  endtask

  task automatic test_seek_down_running();
    logic [1:0] ev[2];
    int ea[2];
    ev = '{2'd3, 2'd1};
    ea = '{2, ST + 3};
    do_reset();
    motor_on = 1'b1;
    tick();
    do_seek(7'd34, 0, 7'd0, 2);
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (i >= obs_v.size()) begin
        n_bad++; $display("FAIL down_step%0d: missing, expected stp=%0d at %0d", i, ev[i], ea[i]);
      end else if (obs_v[i] !== ev[i] || obs_at[i] != ea[i]) begin
        n_bad++;
        $display("FAIL down_step%0d: got stp=%0d at %0d, expected stp=%0d at %0d", i, obs_v[i], obs_at[i], ev[i], ea[i]);
      end
    end
    n_cmp++;
    if (cur_ht !== 7'd34 || obs_v.size() != 2) begin
      n_bad++; $display("FAIL down_final: got cur_ht=%0d steps=%0d, expected 34 and 2", cur_ht, obs_v.size());
    end
    n_cmp++;
    if (done_cnt != 1 || done_at != 2 * (ST + 1) + SE + 1) begin
      n_bad++;
      $display("FAIL down_done: got count %0d at %0d, expected count 1 at %0d", done_cnt, done_at, 2 * (ST + 1) + SE + 1);
    end
    motor_on = 1'b0;
  endtask

  task automatic test_clamp();
    motor_on = 1'b1;
    do_seek(7'd0, 0, 7'd0, 2);
    n_cmp++;
    if (cur_ht !== 7'd1 || min_cur < 1 || done_cnt != 1) begin
      n_bad++; $display("FAIL clamp_low: got cur_ht=%0d min=%0d done=%0d, expected 1/1/1", cur_ht, min_cur, done_cnt);
    end
    do_seek(7'd127, 0, 7'd0, 2);
    n_cmp++;
    if (cur_ht !== 7'd80 || max_cur > 80 || done_cnt != 1) begin
      n_bad++; $display("FAIL clamp_high: got cur_ht=%0d max=%0d done=%0d, expected 80/80/1", cur_ht, max_cur, done_cnt);
    end
    motor_on = 1'b0;
  endtask

  task automatic test_same_target();
    do_reset();
    do_seek(7'd36, 0, 7'd0, 2);
    n_cmp++;
    if (obs_v.size() != 0 || mtr1 !== 1'b1 || cur_ht !== 7'd36) begin
      n_bad++;
      $display("FAIL same_no_step: got steps=%0d mtr=%b cur_ht=%0d, expected 0/1/36", obs_v.size(), mtr1, cur_ht);
    end
    n_cmp++;
    if (done_at != SP + SE + 1 || done_cnt != 1) begin
      n_bad++; $display("FAIL same_done: got at %0d count %0d, expected at %0d count 1", done_at, done_cnt, SP + SE + 1);
    end
  endtask

  task automatic test_ignore_in_wait();
    do_reset();
    motor_on = 1'b1;
    tick();
    do_seek(7'd39, 4, 7'd10, 2);
    n_cmp++;
    if (cur_ht !== 7'd39 || obs_v.size() != 3) begin
      n_bad++; $display("FAIL ignore_final: got cur_ht=%0d steps=%0d, expected 39 and 3", cur_ht, obs_v.size());
    end
    n_cmp++;
    if (done_cnt != 1 || done_at != 3 * (ST + 1) + SE + 1) begin
      n_bad++;
      $display("FAIL ignore_done: got count %0d at %0d, expected count 1 at %0d", done_cnt, done_at, 3 * (ST + 1) + SE + 1);
    end
    motor_on = 1'b0;
  endtask

  task automatic test_reset_in_wait();
    int dn, chg;
    do_reset();
    motor_on = 1'b1;
    tick();
    target_ht = 7'd40; seek_req = 1'b1;
    tick();
    seek_req = 1'b0;
    repeat (17) tick();
    n_cmp++;
    if (cur_ht !== 7'd40 || busy !== 1'b1) begin
      n_bad++; $display("FAIL rst_wait_pre: got cur_ht=%0d busy=%b, expected 40/1", cur_ht, busy);
    end
    reset = 1'b1; motor_on = 1'b0;
    tick();
    reset = 1'b0;
    n_cmp++;
    if ({cur_ht, stp, mtr, busy, done} !== {7'd36, 2'd0, 1'b0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL rst_wait_post: got cur_ht=%0d stp=%0d mtr=%b busy=%b done=%b, expected 36/0/0/0/0",
               cur_ht, stp, mtr, busy, done);
    end
    dn = 0; chg = 0;
    repeat (30) begin
      tick();
      if (done === 1'b1) dn++;
      if (stp !== 2'd0) chg++;
    end
    n_cmp++;
    if (dn != 0 || chg != 0) begin
      n_bad++; $display("FAIL rst_wait_quiet: got done=%0d stp_changes=%0d, expected 0/0", dn, chg);
    end
  endtask

  task automatic test_random();
    logic [6:0] t, t2;
    int sec;
    for (int k = 0; k < 8; k++) begin
      motor_on = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 15)) tick();
      t   = 7'($urandom_range(0, 127));
      t2  = 7'($urandom_range(0, 127));
      sec = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 6)) : 0;
      do_seek(t, sec, t2, 2);
      n_cmp++;
      if (cur_ht !== clamp_ht(t) || done_cnt != 1) begin
        n_bad++;
        $display("FAIL random_seek%0d: got cur_ht=%0d done=%0d, expected %0d and 1", k, cur_ht, done_cnt, clamp_ht(t));
      end
    end
    motor_on = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "timeout");
  end

  initial begin
    tick();
    test_reset();
    test_seek_up_spinup();
    test_seek_down_running();
    test_clamp();
    test_same_target();
    test_ignore_in_wait();
    test_reset_in_wait();
    test_random();
    repeat (HO + 4) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/c1541_head_seek.md
C1541_HEAD_SEEK -- requirements
Module: c1541_head_seek

Interface
REQ-001 SHALL have parameter STEP_CYCLES, default 96000, clk32 cycles between consecutive phase changes (3 ms).
REQ-002 SHALL have parameter SPINUP_CYCLES, default 3200000, clk32 cycles of motor-on before the first step when the motor was off.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 480000, clk32 cycles after the last step before completion.
REQ-004 SHALL have parameter HOLD_CYCLES, default 32000000, clk32 cycles mtr stays high after completion.
REQ-005 SHALL have port clk32, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit, synchronous, active-high.
REQ-007 SHALL have port seek_req, input, 1 bit, single-cycle seek request.
REQ-008 SHALL have port target_ht, input, 7 bits, target half-track, sampled when seek_req is accepted.
REQ-009 SHALL have port motor_on, input, 1 bit, external motor request.
REQ-010 SHALL have port stp, output, 2 bits, stepper phase.
REQ-011 SHALL have port mtr, output, 1 bit, spindle motor enable.
REQ-012 SHALL have port cur_ht, output, 7 bits, current half-track position.
REQ-013 SHALL have port busy, output, 1 bit, high while a seek is in progress.
REQ-014 SHALL have port done, output, 1 bit, single-cycle completion pulse.

Function
REQ-015 SHALL drive stp = {cur_ht[0], cur_ht[1]} combinationally, so an increment produces phase order 0,2,1,3,0 and a decrement produces 0,3,1,2,0.
REQ-016 SHALL clamp the sampled target to the range 1..80: values 0 become 1, values above 80 become 80.
REQ-017 SHALL implement the states IDLE, SPINUP, STEP, WAIT and SETTLE.
REQ-018 SHALL accept seek_req only in IDLE; a seek_req arriving in any other state is ignored with no effect.
REQ-019 On acceptance with the motor already running, SHALL go IDLE->SETTLE directly if the clamped target equals cur_ht, otherwise IDLE->STEP.
REQ-020 On acceptance with the motor off, SHALL go IDLE->SPINUP and hold there SPINUP_CYCLES cycles, then go to STEP, or to SETTLE if the target equals cur_ht.
REQ-021 In STEP, SHALL change cur_ht by +1 or -1 toward the target within one cycle, then enter WAIT.
REQ-022 In WAIT, SHALL hold STEP_CYCLES cycles, then go to STEP if cur_ht differs from the target, otherwise to SETTLE.
REQ-023 In SETTLE, SHALL hold SETTLE_CYCLES cycles, then pulse done for exactly one cycle and return to IDLE.
REQ-024 SHALL assert busy from the cycle after acceptance until the cycle done is asserted, inclusive.
REQ-025 SHALL force mtr high in SPINUP, STEP, WAIT and SETTLE, and whenever motor_on=1.
REQ-026 In IDLE with motor_on=0, SHALL keep mtr high for HOLD_CYCLES after done or after motor_on falls, then drive it low.
REQ-027 SHALL re-arm the hold counter to HOLD_CYCLES on every done pulse.
REQ-028 SHALL change cur_ht, and hence stp, only while mtr=1.
REQ-029 SHALL keep cur_ht within 1..80 at all times.
REQ-030 SHALL size counters to hold the largest parameter value without wrap.
REQ-031 SHALL treat a parameter value of 0 as a one-cycle state.

Reset
REQ-032 With reset=1, SHALL drive on the next edge: state IDLE, cur_ht=36, stp=0, mtr=0, busy=0, done=0, all counters cleared.
REQ-033 Reset asserted mid-seek SHALL abort the seek with no done pulse and no further phase change.
REQ-034 Reset SHALL take priority over a simultaneous seek_req.

Verification (bench parameters: STEP_CYCLES=4, SPINUP_CYCLES=8, SETTLE_CYCLES=6, HOLD_CYCLES=10)
REQ-035 Bench SHALL cover: reset, then seek_req with target_ht=38 -> mtr=1 immediately, 8 spin-up cycles, stp sequence 0->2->1 with steps 5 cycles apart, cur_ht=38, done after 6 settle cycles, mtr low 10 cycles later.
REQ-036 Bench SHALL cover: from cur_ht=36 with the motor running, target_ht=34 -> no spin-up, stp sequence 0->3->1, cur_ht=34, done asserted once.
REQ-037 Bench SHALL cover: target_ht=0, then target_ht=127 -> the first seek stops at cur_ht=1, the second at cur_ht=80, never beyond either limit.
REQ-038 Bench SHALL cover: target_ht equal to cur_ht with the motor off -> SPINUP, then SETTLE, then done, with no stp change.
REQ-039 Bench SHALL cover: a second seek_req during WAIT -> ignored, the first seek completes unchanged.
REQ-040 Bench SHALL cover: reset asserted during WAIT at cur_ht=40 -> next cycle cur_ht=36, stp=0, mtr=0, busy=0, and no done pulse.
REQ-041 Bench SHALL include a scoreboard that checks the stp sequence and cur_ht on every cycle.
